// File: rtl/pond_out_fifo.sv
// pond_out_fifo: show-ahead output FIFO between the pond read schedule and a ready/valid consumer.
// Optional POND_OUT_FIFO_BYPASS_EN: zero-latency pass-through when empty and the consumer is ready.
module pond_out_fifo #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tile_en,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        valid_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      en, clr, pop, push, drop, bypass;

    assign en    = tile_en;
    assign clr   = en & flush;
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);

`ifdef POND_OUT_FIFO_BYPASS_EN
    assign bypass    = en & empty & valid_in & ready_in;
    assign valid_out = tile_en & (~empty | valid_in);
    assign data_out  = empty ? data_in : mem_q[rd_ptr_q];
`else
    assign bypass    = 1'b0;
    assign valid_out = tile_en & ~empty;
    assign data_out  = mem_q[rd_ptr_q];
`endif

    // pop only ever consumes a stored word; a bypassed word never touches the pointers
    assign pop  = en & ~empty & ready_in;
    assign push = en & valid_in & ~bypass & (~full | pop);
    assign drop = en & valid_in & full & ~pop;

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = clr ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = clr ? '0 : rd_ptr_q + AW'(pop);
        count_d    = clr ? '0 : count_q + CW'(push) - CW'(pop);
        overflow_d = clr ? 1'b0 : overflow_q | drop;
        drop_cnt_d = clr ? '0 : drop_cnt_q + DROP_CNT_WIDTH'(drop & ~(&drop_cnt_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: doc/pond_out_fifo.md
Name: pond_out_fifo

Overview:
- Downstream stage of the pond tile.
- Captures each pond read word on the cycle the read schedule generator asserts valid, and buffers it in a small show-ahead FIFO.
- Presents the words to the interconnect with a ready/valid handshake, decoupling the fixed-schedule pond from a consumer that can stall.
- Counts words lost to overflow, so schedule misconfiguration is observable.

Parameters:
- DATA_WIDTH, 16, width of one pond word.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  tile clock.
- rst_n  input  1  asynchronous active-low reset.
- tile_en  input  1  tile enable; when 0, all state holds.
- flush  input  1  synchronous clear of FIFO contents and counters.
- data_in  input  DATA_WIDTH  pond read data (pond data_out[0]).
- valid_in  input  1  pond read-schedule valid; word is present this cycle only.
- data_out  output  DATA_WIDTH  head-of-FIFO word.
- valid_out  output  1  head word available.
- ready_in  input  1  consumer accepts the head word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: at least one word dropped since reset/flush.
- drop_count  output  DROP_CNT_WIDTH  dropped words, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count, overflow and drop_count go to 0.
  - valid_out=0, empty=1, full=0.
  - Storage is not reset; data_out is don't-care while empty.
- Reset asserted mid-operation discards all contents immediately; no word is emitted after release until a new push.
- Effective enable: en = tile_en.
  - With en=0, no push, pop, flush or counter update occurs.
  - valid_out is forced 0 while en=0; valid_in arriving then is ignored and not counted as a drop.
- pop = en & valid_out & ready_in.
- push = en & valid_in & (~full | pop).
- drop = en & valid_in & full & ~pop.
- Storage is show-ahead:
  - data_out = mem[rd_ptr] combinationally.
  - valid_out = ~empty & tile_en.
- Latency: a word pushed at edge N appears on data_out/valid_out after edge N, i.e. 1 cycle valid_in-to-valid_out.
  - When empty, a same-cycle push and ready does not bypass; the word is stored (see Optional Feature).
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- count is updated each cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: both take effect; count stays DEPTH; no drop.
- Drop:
  - The incoming word is discarded and FIFO contents are unchanged.
  - drop_count increments and saturates at all-ones.
  - overflow is set and held.
- flush (when en=1) has priority over push/pop in the same cycle.
  - Clears pointers, count, overflow and drop_count at the next edge.
  - A concurrent valid_in word is discarded and not counted.
- The consumer may drop ready_in at any time. data_out holds stable while valid_out=1 and ready_in=0; no new push alters the head.

Optional Feature:
- Macro: POND_OUT_FIFO_BYPASS_EN.
- Defined:
  - When empty, tile_en=1, valid_in=1 and ready_in=1, data_in drives data_out and valid_out=1 combinationally in the same cycle.
  - The word is consumed without being stored; count and pointers are unchanged.
  - When empty and ready_in=0, the word is stored normally.
  - valid_out = tile_en & (~empty | valid_in).
- Undefined: no combinational path from data_in/valid_in to outputs; 1-cycle latency as above.

Test Plan:
- Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles with ready_in=0 -> count=3, data_out=0x0011 and stable. Raise ready_in -> outputs 0x0011, 0x0022, 0x0033 on successive cycles, then empty=1, valid_out=0.
- DEPTH=4: push 6 words (0xA0..0xA5) with ready_in=0 -> full=1, words 0xA4 and 0xA5 dropped, drop_count=2, overflow=1. Drain -> 0xA0..0xA3 in order.
- Full with valid_in=1, ready_in=1 for 3 cycles, data 0xB0..0xB2 -> count stays 4, drop_count unchanged. Pointers wrap, and the drain order is preserved across the wrap.
- With 2 words stored, assert flush together with valid_in=1 -> next cycle count=0, empty=1, drop_count=0, overflow=0, and the concurrent word is lost.
- tile_en=0 for 3 cycles with valid_in=1 and ready_in=1 while holding 2 words -> valid_out=0, count stays 2, drop_count unchanged. Re-enable -> same 2 words emerge.
- Assert rst_n low mid-drain while holding 3 words -> empty=1 and valid_out=0 immediately, without waiting for a clock edge. With POND_OUT_FIFO_BYPASS_EN defined and the FIFO empty, valid_in=1 with data 0x0055 and ready_in=1 -> data_out=0x0055 and valid_out=1 in the same cycle, count remains 0.
